stream_fifo: RTL

Synchronous first-word-fall-through FIFO with valid/ready handshakes on both sides. It sits directly upstream of a processing stage and decouples that stage's `ready` back-pressure from the producer. Combinational paths from `out_ready` to `in_ready` are broken by design, so stages can be chained without timing loops.

---
 rtl/stream_pkg.sv | 22 ++
 rtl/stream_fifo_mem.sv | 37 +++
 rtl/stream_fifo.sv | 107 ++++++++++
 3 files changed

// File: rtl/stream_pkg.sv
// Purpose : shared definitions for valid/ready stream stages (pointer sizing, beat template).
// Latency : n/a (types and constant functions only).
// Backpressure: n/a; consumers of stream_beat_t carry their own ready signal.
package stream_pkg;

  // Width of a FIFO pointer: address bits plus one wrap bit, so that
  // "pointers equal" means empty and "addresses equal, wrap bits differ" means full.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Payload width of the beat template below. Neighbouring stages that need
  // a different width declare their own struct with the same field layout.
  localparam int BEAT_DATA_W = 32;

  // Template for one beat on a stream: payload plus its valid qualifier.
  typedef struct packed {
    logic [BEAT_DATA_W-1:0] data;
    logic                   valid;
  } stream_beat_t;

endpackage : stream_pkg

// File: rtl/stream_fifo_mem.sv
// Purpose : DEPTH x DATA_W register array, one synchronous write port and one async read port.
// Latency : write visible on rdata the cycle after the write edge; read is combinational.
// Backpressure: none; the caller guarantees it never writes the slot it is reading.
//
// Ports:
//   clk   - write clock
//   we    - write enable, samples waddr/wdata on the rising edge
//   waddr - write address
//   wdata - write payload
//   raddr - read address
//   rdata - storage contents at raddr (combinational)
module stream_fifo_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  // Storage is deliberately not reset: the owning FIFO's pointers decide
  // which slots hold meaningful data, so clearing the array buys nothing.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : stream_fifo_mem

// File: rtl/stream_fifo.sv
// Purpose : first-word-fall-through FIFO decoupling a consumer's ready from its producer.
// Latency : 1 cycle write-to-read; 1 word/cycle sustained with both sides streaming.
// Backpressure: in_ready = !full from registered pointers only, so out_ready never reaches in_ready.
//
// Ports:
//   clk, rst_n             - clock; asynchronous active-low reset (clears pointers only)
//   in_data/in_valid/in_ready    - producer side, push when in_valid && in_ready
//   out_data/out_valid/out_ready - consumer side, pop when out_valid && out_ready
//   count                  - occupancy 0..DEPTH
//   full/empty/almost_full - occupancy flags (almost_full when count >= AF_LEVEL)
module stream_fifo
  import stream_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  // Elaboration-time parameter sanity checks.
  if (DATA_W < 1) begin : g_bad_data_w
    $error("stream_fifo: DATA_W must be >= 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("stream_fifo: DEPTH must be a power of two and >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af_level
    $error("stream_fifo: AF_LEVEL must be in 1..DEPTH");
  end

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Handshakes. in_ready/out_valid come from registered pointers, so a
  // simultaneous push+pop on a full FIFO only pops (no same-cycle refill),
  // and on an empty FIFO only pushes.
  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Pointers wrap naturally modulo 2*DEPTH; the extra bit tracks the lap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Modulo-2*DEPTH difference gives occupancy directly, including across wrap.
  assign count       = wr_ptr - rd_ptr;
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign almost_full = (count >= PW'(AF_LEVEL));
  assign in_ready    = !full;
  assign out_valid   = !empty;

  stream_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (out_data)
  );

`ifndef SYNTHESIS
  // Occupancy can never exceed the array size.
  a_count_range : assert property (
    @(posedge clk) disable iff (!rst_n) count <= PW'(DEPTH)
  );

  // A stalled head word must not change under the consumer: writes never
  // target the read slot while it holds valid data.
  a_head_stable : assert property (
    @(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> $stable(out_data)
  );
`endif

endmodule : stream_fifo
